program_loader: RTL and testbench

Boot-time instruction loader that sits directly upstream of the pipelined MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles it into little-endian 32-bit words, and writes those words sequentially into program memory starting at byte address 0. It holds the processor in reset until a complete, length-checked image has been written, then releases it.

---
 rtl/loader_pkg.sv | 35 +++
 rtl/byte_assembler.sv | 68 ++++++
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the boot-time program loader.
//   loader_state_t   : loader FSM states
//   LEN_BYTES        : bytes in the little-endian word-count header
//   BYTES_PER_WORD   : bytes assembled into one instruction word
//   INSTR_BASE_ADDR  : byte address of the first instruction written
// ---------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  localparam int          LEN_BYTES       = 2;
  localparam int          BYTES_PER_WORD  = 4;
  localparam logic [31:0] INSTR_BASE_ADDR = 32'h0;

  // States in which a new load request is honoured.
  function automatic logic accepts_start(loader_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

  // States in which a load is in progress.
  function automatic logic is_busy(loader_state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// ---------------------------------------------------------------------------
// byte_assembler
// Collects bytes into a little-endian 32-bit word: every accepted byte is
// shifted in at the top lane, so after four shifts the first byte sits in
// bits 7:0.
//   clk, reset (async, active-low)
//   clear      : drop any partial word and restart the byte count
//   shift_en   : take data_in this cycle
//   data_in    : incoming byte
//   word       : assembled word
//   byte_count : bytes taken modulo 4 (3 means the next byte completes a word)
//   word_full  : a complete word is held (set by the 4th byte)
// ---------------------------------------------------------------------------
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  data_in,
  output logic [31:0] word,
  output logic [1:0]  byte_count,
  output logic        word_full
);

  logic [7:0] lane_reg [BYTES_PER_WORD];
  logic [1:0] count_reg;
  logic       full_reg;

  // One register per byte lane; the top lane loads the new byte and each
  // lower lane takes the lane above it.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      if (gi == BYTES_PER_WORD - 1) begin : g_top
        always_ff @(posedge clk or negedge reset) begin
          if (!reset)        lane_reg[gi] <= 8'h00;
          else if (clear)    lane_reg[gi] <= 8'h00;
          else if (shift_en) lane_reg[gi] <= data_in;
        end
      end else begin : g_low
        always_ff @(posedge clk or negedge reset) begin
          if (!reset)        lane_reg[gi] <= 8'h00;
          else if (clear)    lane_reg[gi] <= 8'h00;
          else if (shift_en) lane_reg[gi] <= lane_reg[gi+1];
        end
      end
      assign word[gi*8 +: 8] = lane_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= 2'd0;
      full_reg  <= 1'b0;
    end else if (clear) begin
      count_reg <= 2'd0;
      full_reg  <= 1'b0;
    end else if (shift_en) begin
      count_reg <= count_reg + 2'd1;
      full_reg  <= (count_reg == 2'd3);
    end
  end

  assign byte_count = count_reg;
  assign word_full  = full_reg;

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Boot-time loader: receives a byte stream (2-byte little-endian word count,
// then the words little-endian), writes the words to instruction memory from
// byte address 0 upward, and keeps the CPU in reset until a complete image
// whose length fits in memory has been written.
//   clk, reset (async, active-low)
//   start                 : begin a load (honoured in IDLE, DONE, ERR)
//   rx_data/rx_valid/rx_ready : byte stream handshake
//   imem_we/imem_addr/imem_wdata : instruction memory write port
//   cpu_reset             : active-low CPU reset, high only in DONE
//   busy                  : load in progress
//   error                 : bad length header
//   words_loaded          : words written since the last start
// ---------------------------------------------------------------------------
module program_loader
  import loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 128,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 imem_we,
  output logic [31:0]          imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_loaded
);

  localparam int IDX_W    = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int HDR_BITS = LEN_BYTES * 8;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MEMORY_DEPTH);

  loader_state_t        state_reg, state_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic [LEN_WIDTH-1:0] words_loaded_reg, words_loaded_next;
  logic [IDX_W-1:0]     word_index_reg, word_index_next;

  logic                 accept;
  logic                 start_ok;
  logic                 shift_en;
  logic [HDR_BITS-1:0]  hdr_value;
  logic [31:0]          asm_word;
  logic [1:0]           asm_count;
  logic                 asm_full;

  // rx_ready depends on state only, so there is no path from rx_valid.
  assign rx_ready  = (state_reg == ST_LEN_LO) || (state_reg == ST_LEN_HI) ||
                     (state_reg == ST_DATA);
  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && accepts_start(state_reg);
  assign shift_en  = accept && (state_reg == ST_DATA);
  assign hdr_value = {rx_data, len_reg[7:0]};

  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .shift_en   (shift_en),
    .data_in    (rx_data),
    .word       (asm_word),
    .byte_count (asm_count),
    .word_full  (asm_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_IDLE;
      len_reg          <= '0;
      words_loaded_reg <= '0;
      word_index_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      len_reg          <= len_next;
      words_loaded_reg <= words_loaded_next;
      word_index_reg   <= word_index_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    len_next          = len_reg;
    words_loaded_next = words_loaded_reg;
    word_index_next   = word_index_reg;

    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_next        = ST_LEN_LO;
          words_loaded_next = '0;
          word_index_next   = '0;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_next   = {len_reg[LEN_WIDTH-1:8], rx_data};
          state_next = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_next = LEN_WIDTH'(hdr_value);
          // An empty image or one larger than memory is rejected before any
          // write, which also guarantees word_index never runs past the end.
          if ((hdr_value == '0) || (LEN_WIDTH'(hdr_value) > MAX_LEN))
            state_next = ST_ERR;
          else
            state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (shift_en && (asm_count == 2'd3))
          state_next = ST_WRITE;
      end
      ST_WRITE: begin
        word_index_next   = word_index_reg + IDX_W'(1);
        words_loaded_next = words_loaded_reg + LEN_WIDTH'(1);
        if ((words_loaded_reg + LEN_WIDTH'(1)) == len_reg)
          state_next = ST_DONE;
        else
          state_next = ST_DATA;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign imem_we      = (state_reg == ST_WRITE) && asm_full;
  assign imem_addr    = INSTR_BASE_ADDR |
                        {{(32-IDX_W-2){1'b0}}, word_index_reg, 2'b00};
  assign imem_wdata   = asm_word;
  // Drops in the very cycle a restart is requested from DONE.
  assign cpu_reset    = (state_reg == ST_DONE) && !start;
  assign busy         = is_busy(state_reg);
  assign error        = (state_reg == ST_ERR);
  assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        error;
  logic [15:0] words_loaded;

  program_loader #(.MEMORY_DEPTH(128), .LEN_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef logic [7:0]  bytes_t[$];
  typedef logic [31:0] words_t[$];

  wr_t         exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          last_we_cyc = 0;
  logic [31:0] last_we_addr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      last_we_cyc  = cyc;
      last_we_addr = imem_addr;
      $display("write addr=0x%08h data=0x%08h pending=%0d", imem_addr, imem_wdata, exp_q.size());
      if (exp_q.size() == 0) begin
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_write observed addr=0x%08h data=0x%08h expected no write", imem_addr, imem_wdata);
        end
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", imem_addr, e.addr);
        chk("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    $display("check reset outputs (%s)", tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the last byte is taken.
  task automatic send_stream(input bytes_t b, input bit rnd, input bit hold_start);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < b.size() && guard < 20000) begin
      rx_data  = b[i];
      rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = hold_start;
      acc      = rx_valid && rx_ready;
      @(negedge clk);
      if (acc) i++;
      guard++;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    chk("stream_bytes_accepted", 32'(i), 32'(b.size()));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_load(input words_t w, input bit rnd, input bit hold_start);
    bytes_t b;
    int     n;
    int     start_cyc;
    int     t;
    wr_t    e;
    n = w.size();
    b = {};
    b.push_back(n[7:0]);
    b.push_back(n[15:8]);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) b.push_back(w[k][8*j +: 8]);
      e.addr = 32'(k * 4);
      e.data = w[k];
      exp_q.push_back(e);
    end
    $display("load words=%0d rnd=%0d hold_start=%0d", n, rnd, hold_start);
    start     = 1'b1;
    start_cyc = cyc;
    #1;
    chk("cpu_reset_low_during_start", 32'(cpu_reset), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("words_cleared_after_start", 32'(words_loaded), 32'd0);
    send_stream(b, rnd, hold_start);
    t = 0;
    while (cpu_reset !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("cpu_reset_done", 32'(cpu_reset), 32'd1);
    chk("cpu_reset_delay", 32'(cyc - last_we_cyc), 32'd1);
    chk("words_loaded", 32'(words_loaded), 32'(n));
    chk("busy_done", 32'(busy), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("last_write_addr", last_we_addr, 32'((n - 1) * 4));
    if (!rnd) chk("load_cycles", 32'(last_we_cyc - start_cyc), 32'(2 + 5 * n));
  endtask

  task automatic bad_header(input logic [7:0] lo, input logic [7:0] hi);
    bytes_t b;
    b = {lo, hi};
    $display("bad header 0x%02h%02h", hi, lo);
    pulse_start();
    send_stream(b, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("err_error", 32'(error), 32'd1);
    chk("err_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_rx_ready", 32'(rx_ready), 32'd0);
  endtask

  initial begin
    words_t w;
    words_t w3;
    bytes_t b;

    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word image, back to back.
    w = {32'h20082013, 32'h24090005};
    do_load(w, 1'b0, 1'b0);

    // Zero-length header, then recovery with a one-word image.
    bad_header(8'h00, 8'h00);
    w = {32'hCAFEF00D};
    do_load(w, 1'b0, 1'b0);
    chk("error_cleared", 32'(error), 32'd0);

    // One word too many for memory.
    bad_header(8'h81, 8'h00);

    // Exactly full memory.
    w = {};
    for (int k = 0; k < 128; k++) w.push_back((32'(k) * 32'h01000193) ^ 32'hDEAD0000);
    do_load(w, 1'b0, 1'b0);
    chk("full_image_last_addr", last_we_addr, 32'h1FC);

    // Same three words back to back and with a ragged valid.
    w3 = {32'h8C080004, 32'hAC09FFF0, 32'h1000FFFF};
    do_load(w3, 1'b0, 1'b0);
    do_load(w3, 1'b1, 1'b0);

    // Reset mid-word, then a clean reload from address 0.
    b = {8'h03, 8'h00, 8'hAA, 8'hBB};
    pulse_start();
    send_stream(b, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_load");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = {32'h11223344};
    do_load(w, 1'b0, 1'b0);

    // start held high for the whole load, including every WRITE cycle.
    do_load(w3, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
